// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one multiplier core between two requesters.
// Optional watchdog on the core's done strobe: define MUL_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; combinational ready to the grantee
// S_ISSUE | operands latched, mul_go high for this single cycle
// S_WAIT  | waiting for mul_done (or the watchdog, when enabled)
// S_RESP  | product held on rsp_data until the grantee takes it
module vedic_mul_arbiter #(
    parameter int WIDTH   = 4,
    parameter int HB_DIV  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_err,
    output logic               mul_go,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    input  logic               mul_done,
    output logic [15:0]        ops_count,
    output logic               busy_led
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] HB_LOAD = 8'(HB_DIV - 1);

    state_t             r_state;
    logic               r_ptr;
    logic               r_gnt;
    logic               r_go;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_rsp_data;
    logic [1:0]         r_rsp_valid;
    logic [15:0]        r_ops;
    logic [7:0]         r_hb_cnt;
    logic               r_led;

    logic w_idle;
    logic w_rdy0;
    logic w_rdy1;

`ifdef MUL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_rsp_err;

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Pointer's requester wins; the other one only gets in when the pointer side is idle.
    assign w_idle = (r_state == S_IDLE);
    assign w_rdy0 = w_idle && req0_valid && (!r_ptr || !req1_valid);
    assign w_rdy1 = w_idle && req1_valid && (r_ptr || !req0_valid);

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign mul_go     = r_go;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign ops_count  = r_ops;
    assign busy_led   = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_go        <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
            r_ops       <= 16'd0;
            r_hb_cnt    <= HB_LOAD;
            r_led       <= 1'b0;
`ifdef MUL_TIMEOUT_EN
            r_tmo       <= TMO_LOAD;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_go <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_rdy0 || w_rdy1) begin
                        r_mul_a <= w_rdy1 ? req1_a : req0_a;
                        r_mul_b <= w_rdy1 ? req1_b : req0_b;
                        r_gnt   <= w_rdy1;
                        r_ptr   <= ~w_rdy1;
                        r_go    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MUL_TIMEOUT_EN
                    r_tmo   <= TMO_LOAD;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_rsp_data  <= mul_p;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
`ifdef MUL_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef MUL_TIMEOUT_EN
                    else if (r_tmo == '0) begin
                        r_rsp_data  <= '0;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= 2'b00;
                        r_ops       <= r_ops + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Heartbeat runs only while an operation is in flight.
            if (r_state == S_IDLE) begin
                r_hb_cnt <= HB_LOAD;
                r_led    <= 1'b0;
            end else if (r_hb_cnt == 8'd0) begin
                r_hb_cnt <= HB_LOAD;
                r_led    <= ~r_led;
            end else begin
                r_hb_cnt <= r_hb_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Self-checking bench for vedic_mul_arbiter: vector table, scoreboard and corner sequences.
module tb_vedic_mul_arbiter;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_err;
    logic           mul_go;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           mul_done;
    logic [15:0]    ops_count;
    logic           busy_led;

    always #5 clk = ~clk;

    vedic_mul_arbiter #(.WIDTH(W), .HB_DIV(8), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done),
        .ops_count(ops_count), .busy_led(busy_led)
    );

    typedef struct {
        int id;
        int a;
        int b;
        int dly;
        int bp;
        int exp_p;
    } vec_t;

    vec_t vecs[6];
    int   sb_id[$];
    int   sb_p[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   exp_ops = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Entered at the negedge right after the transfer edge (DUT in ISSUE).
    task automatic serve(input int id, input int a, input int b, input int dly,
                         input int bp, input bit stray);
        int k;
        int e_id;
        int e_p;
        logic [2*W-1:0] held;
        k = 0;
        chk("mul_go_issue", mul_go, 1);
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        chk("ready_busy", {req0_ready, req1_ready}, 0);
        if (stray) begin
            mul_done = 1'b1;
            mul_p    = 8'hAA;
        end
        @(negedge clk); k++;
        mul_done = 1'b0;
        chk("mul_go_pulse", mul_go, 0);
        chk("rsp_valid_wait", rsp_valid, 0);
        repeat (dly - 1) begin @(negedge clk); k++; end
        mul_done = 1'b1;
        mul_p    = (2*W)'(a * b);
        @(negedge clk); k++;
        mul_done = 1'b0;
        mul_p    = 8'h5A;
        e_id = -1;
        e_p  = -1;
        if (sb_id.size() > 0) begin
            e_id = sb_id.pop_front();
            e_p  = sb_p.pop_front();
        end
        chk("rsp_valid", rsp_valid, (e_id < 0) ? 0 : (1 << e_id));
        chk("rsp_data", rsp_data, e_p);
        chk("rsp_err", rsp_err, 0);
        chk("busy_led_resp", busy_led, (k / 8) % 2);
        held = rsp_data;
        rsp_ready = 2'(1 << (1 - id));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk); k++;
            chk("bp_valid", rsp_valid, 1 << id);
            chk("bp_data", rsp_data, held);
            chk("bp_ready", {req0_ready, req1_ready}, 0);
            chk("bp_busy_led", busy_led, (k / 8) % 2);
        end
        rsp_ready = 2'(1 << id);
        exp_ops++;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("rsp_valid_clr", rsp_valid, 0);
        chk("ops_count", ops_count, exp_ops);
    endtask

    task automatic request(input int id, input int a, input int b, input int exp_p);
        int n;
        if (id == 0) begin req0_valid = 1'b1; req0_a = W'(a); req0_b = W'(b); end
        else begin req1_valid = 1'b1; req1_a = W'(a); req1_b = W'(b); end
        n = 0;
        #1;
        while (!(id == 0 ? req0_ready : req1_ready) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("req_ready", (id == 0) ? req0_ready : req1_ready, 1);
        chk("other_ready", (id == 0) ? req1_ready : req0_ready, 0);
        sb_id.push_back(id);
        sb_p.push_back(exp_p);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_id;
        vecs[0] = '{0, 3, 5, 2, 0, 15};
        vecs[1] = '{1, 15, 15, 1, 0, 225};
        vecs[2] = '{0, 0, 9, 3, 1, 0};
        vecs[3] = '{1, 15, 1, 1, 0, 15};
        vecs[4] = '{0, 7, 6, 2, 10, 42};
        vecs[5] = '{1, 8, 8, 5, 2, 64};

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 0; mul_p = 0; mul_done = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_mul_go", mul_go, 0);
        chk("rst_ops", ops_count, 0);
        chk("rst_led", busy_led, 0);
        chk("rst_err", rsp_err, 0);

        for (int i = 0; i < 6; i++) begin
            request(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_p);
            serve(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].dly, vecs[i].bp, 1'b0);
        end

        // Stray done in IDLE, then another on the mul_go cycle.
        mul_done = 1'b1; mul_p = 8'd99;
        @(negedge clk);
        mul_done = 1'b0;
        @(negedge clk);
        chk("stray_idle_valid", rsp_valid, 0);
        chk("stray_idle_ops", ops_count, exp_ops);
        request(0, 9, 9, 81);
        serve(0, 9, 9, 2, 0, 1'b1);

        // Reset in WAIT, then a late done must be ignored.
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        chk("midrst_mul_a", mul_a, 0);
        chk("midrst_ops", ops_count, 0);
        chk("midrst_go", mul_go, 0);
        mul_done = 1'b1; mul_p = 8'd25;
        @(negedge clk);
        mul_done = 1'b0;
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", rsp_data, 0);
        chk("midrst_ops2", ops_count, 0);

        // Contention: both valid continuously, pointer starts at 0 after reset.
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
        req1_valid = 1'b1; req1_a = 4'd2;  req1_b = 4'd7;
        exp_id = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_one_ready", int'(req0_ready) + int'(req1_ready), 1);
            chk("cont_grant", req1_ready, exp_id);
            sb_id.push_back(exp_id);
            sb_p.push_back(exp_id == 0 ? 225 : 14);
            @(negedge clk);
            serve(exp_id, exp_id == 0 ? 15 : 2, exp_id == 0 ? 15 : 7, 2, 1, 1'b0);
            exp_id = 1 - exp_id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef MUL_TIMEOUT_EN
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (32) @(negedge clk);
        chk("tmo_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("tmo_valid", rsp_valid, 2);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_err", rsp_err, 1);
        mul_done = 1'b1; mul_p = 8'd77;
        @(negedge clk);
        mul_done = 1'b0;
        chk("tmo_late_data", rsp_data, 0);
        rsp_ready = 2'b10;
        exp_ops++;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("tmo_ops", ops_count, exp_ops);
        chk("tmo_valid_clr", rsp_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vedic_mul_arbiter.md
Name: vedic_mul_arbiter

Overview:
Controller that shares one multiplier core between two requesters. It grants round-robin, latches operands and issues a one-cycle start pulse to the core. It then waits for the core's done strobe, captures the product and returns it to the granted requester over a valid/ready handshake. It sits between the requester logic and the multiplier datapath, and also drives a busy heartbeat output for an LED.

Parameters:
WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.
HB_DIV, 8, heartbeat half-period in clock cycles while busy; legal values are 2 to 255.
TIMEOUT, 32, watchdog limit in cycles; used only when MUL_TIMEOUT_EN is defined.

Ports:
clk  in  1  single system clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0 operands accepted this cycle.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req1_valid  in  1  requester 1 has an operation pending.
req1_ready  out  1  requester 1 operands accepted this cycle.
req1_a  in  WIDTH  requester 1 operand A.
req1_b  in  WIDTH  requester 1 operand B.
rsp_valid  out  2  one-hot; bit i means the result for requester i is held.
rsp_ready  in  2  bit i means requester i takes the result.
rsp_data  out  2*WIDTH  product being returned.
rsp_err  out  1  timeout flag qualifying rsp_data.
mul_go  out  1  one-cycle start pulse to the core.
mul_a  out  WIDTH  latched operand A to the core.
mul_b  out  WIDTH  latched operand B to the core.
mul_p  in  2*WIDTH  core product.
mul_done  in  1  core product valid strobe.
ops_count  out  16  count of completed operations.
busy_led  out  1  heartbeat output.

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - All outputs are 0, including ops_count, rsp_data, mul_a and mul_b.
  - Priority pointer is set to requester 0.
  - Reset mid-operation abandons the operation; a later mul_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the pointer's requester if it is valid, else to the other requester if valid.
  - reqN_ready is combinational: it is 1 only in IDLE, only for the granted requester.
  - A transfer occurs on valid&&ready. It latches a and b into mul_a/mul_b and the grant id, sets the pointer to the other requester, and moves to ISSUE.
  - With no valid request, the block stays in IDLE.
- ISSUE: mul_go=1 for exactly this cycle, then move to WAIT.
- WAIT:
  - mul_a and mul_b stay stable from the transfer until leaving WAIT.
  - On mul_done=1, capture mul_p into rsp_data, set rsp_err=0 and move to RESP.
  - mul_done is ignored in IDLE, ISSUE and RESP.
  - mul_done arriving in the same cycle as mul_go is also ignored, since that is ISSUE.
- RESP:
  - rsp_valid[grant]=1; rsp_data and rsp_err are held stable.
  - When rsp_ready[grant]=1: ops_count increments (wraps 0xFFFF to 0), rsp_valid clears, and the block returns to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Minimum cycles per operation: transfer (1) + ISSUE (1) + WAIT (at least 1) + RESP (at least 1) = 4. No new request is accepted before RESP completes.
- Requesters keep valid and operands stable until ready. Dropping valid early is legal and simply withdraws the request.
- Simultaneous valid on both requesters: the pointer's requester wins, so back-to-back contention strictly alternates 0,1,0,1.
- busy_led:
  - Toggles every HB_DIV cycles while state≠IDLE.
  - Forced to 0 and its counter cleared in IDLE.

Optional Feature:
MUL_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If mul_done has not arrived after TIMEOUT cycles, the block moves to RESP with rsp_data=0 and rsp_err=1.
  - ops_count still increments on the handshake.
  - A late mul_done is ignored.
- Undefined: no counter; WAIT waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Single request: reset, then req0 a=3 b=5, core returns mul_done 2 cycles after mul_go with mul_p=15. Required: mul_go one cycle, mul_a=3, mul_b=5, rsp_valid=01, rsp_data=15; ops_count=1 after rsp_ready[0].
- Contention: req0 and req1 valid continuously with a=15 b=15 and a=2 b=7. Required: grants alternate 0,1,0,1; products 225 and 14 go to the matching rsp_valid bit; exactly one ready high at a time.
- Backpressure: hold rsp_ready=00 for 10 cycles in RESP. Required: rsp_valid and rsp_data stable; req ready stays 0; busy_led toggles at HB_DIV=8.
- Reset mid-operation: rst=1 during WAIT, then mul_done pulses after reset. Required: outputs 0, state IDLE, no rsp_valid, ops_count=0.
- Stray strobe: mul_done asserted in IDLE and on the mul_go cycle. Required: ignored; the real done later captures the correct product.
- Timeout (MUL_TIMEOUT_EN, TIMEOUT=32): never assert mul_done. Required: 32 cycles into WAIT, rsp_valid set with rsp_data=0 and rsp_err=1; a later mul_done is ignored.
